// File: rtl/regfile_wr_sched.sv
// Write-port scheduler for the register file: round-robin arbitration of N_REQ
// writeback sources onto one registered write port, plus an on-demand clear sweep.
module regfile_wr_sched #(
    parameter int                 N_REQ     = 2,
    parameter int                 ADDR_W    = 6,
    parameter int                 DATA_W    = 32,
    parameter int                 DEPTH     = 32,
    parameter int                 ZERO_PROT = 1,
    parameter logic [DATA_W-1:0]  INIT_VAL  = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic                      init_req,
    output logic                      init_busy,
    output logic                      init_done,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    output logic [15:0]               drop_cnt,
    output logic                      dbg_state
);

    // Handshake: a requester's write transfers in the cycle where its req_valid
    // and req_ready are both high; it appears on wr_* exactly one cycle later.
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {S_RUN = 1'b0, S_INIT = 1'b1} state_t;

    state_t              state, state_nxt;
    logic [PW-1:0]       rr_ptr;
    logic [ADDR_W-1:0]   sweep_cnt;
    logic [PW-1:0]       grant_idx;
    logic                grant_hit;
    int                  cand;
    logic [ADDR_W-1:0]   g_addr;
    logic [DATA_W-1:0]   g_data;
    logic                fire;
    logic                illegal;
    logic                last_sweep;

    // Search from rr_ptr upward, wrapping, and take the first valid requester.
    always_comb begin
        grant_hit = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = 32'(rr_ptr) + k;
            if (cand >= N_REQ) cand = cand - N_REQ;
            if (!grant_hit && req_valid[cand]) begin
                grant_hit = 1'b1;
                grant_idx = PW'(cand);
            end
        end
    end

    assign g_addr     = req_addr[grant_idx*ADDR_W +: ADDR_W];
    assign g_data     = req_data[grant_idx*DATA_W +: DATA_W];
    assign fire       = |req_ready;
    assign illegal    = ((ZERO_PROT != 0) && (g_addr == '0)) || (32'(g_addr) >= $unsigned(DEPTH));
    assign last_sweep = (32'(sweep_cnt) == $unsigned(DEPTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_RUN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN:   if (init_req)   state_nxt = S_INIT;
            S_INIT:  if (last_sweep) state_nxt = S_RUN;
            default: state_nxt = S_RUN;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (!reset && state == S_RUN && !init_req && grant_hit) req_ready[grant_idx] = 1'b1;
        init_busy = (state == S_INIT);
        dbg_state = state;
    end

    // Registered write stage; the sweep presents address sweep_cnt in the same
    // cycle that sweep_cnt holds it, so the entry edge preloads address 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr    <= '0;
            sweep_cnt <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            init_done <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            wr_en     <= 1'b0;
            init_done <= 1'b0;
            case (state)
                S_RUN: begin
                    if (init_req) begin
                        sweep_cnt <= '0;
                        wr_en     <= 1'b1;
                        wr_addr   <= '0;
                        wr_data   <= INIT_VAL;
                    end else if (fire) begin
                        rr_ptr <= (32'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
                        if (illegal) begin
                            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
                        end else begin
                            wr_en   <= 1'b1;
                            wr_addr <= g_addr;
                            wr_data <= g_data;
                        end
                    end
                end
                S_INIT: begin
                    if (last_sweep) begin
                        init_done <= 1'b1;
                    end else begin
                        sweep_cnt <= sweep_cnt + 1'b1;
                        wr_en     <= 1'b1;
                        wr_addr   <= sweep_cnt + 1'b1;
                        wr_data   <= INIT_VAL;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Directed bench for regfile_wr_sched: vector table for single-cycle arbitration
// and drops, hand sequences for contention, saturation, sweep and async reset.
module tb_regfile_wr_sched;

    localparam int N_REQ  = 2;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;
    localparam logic [DATA_W-1:0] INIT_VAL = 32'h0;

    logic                    clk;
    logic                    reset;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic                    init_req;
    logic                    init_busy;
    logic                    init_done;
    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [DATA_W-1:0]       wr_data;
    logic [15:0]             drop_cnt;
    logic                    dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [ADDR_W+DATA_W-1:0] exp_q[$];

    typedef struct {
        logic [1:0]        valid;
        logic [ADDR_W-1:0] a0;
        logic [DATA_W-1:0] d0;
        logic [ADDR_W-1:0] a1;
        logic [DATA_W-1:0] d1;
        logic [1:0]        exp_ready;
        logic              exp_wr_en;
        logic [ADDR_W-1:0] exp_addr;
        logic [DATA_W-1:0] exp_data;
        logic [15:0]       exp_drop;
    } vec_t;

    vec_t vecs[12];

    regfile_wr_sched #(
        .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
        .ZERO_PROT(1), .INIT_VAL(INIT_VAL)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .init_req(init_req), .init_busy(init_busy), .init_done(init_done),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .drop_cnt(drop_cnt), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                         input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
        req_valid = v;
        req_addr  = {a1, a0};
        req_data  = {d1, d0};
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // hold reset with requests pending
        reset    = 1'b1;
        init_req = 1'b0;
        drive(2'b11, 6'd1, 32'h1, 6'd2, 32'h2);
        #12;
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("rst_wr_en", 64'(wr_en), 64'h0);
        chk("rst_wr_addr", 64'(wr_addr), 64'h0);
        chk("rst_wr_data", 64'(wr_data), 64'h0);
        chk("rst_busy", 64'(init_busy), 64'h0);
        chk("rst_done", 64'(init_done), 64'h0);
        chk("rst_drop", 64'(drop_cnt), 64'h0);
        chk("rst_state", 64'(dbg_state), 64'h0);
        @(negedge clk);
        reset = 1'b0;

        // contention: both valid every cycle, grants alternate starting at 0
        for (int i = 0; i < 8; i++) begin
            logic [1:0]        g_exp;
            logic [ADDR_W-1:0] a0, a1;
            logic [DATA_W-1:0] d0, d1;
            logic [ADDR_W+DATA_W-1:0] got, want;
            a0 = ADDR_W'(10 + i);
            a1 = ADDR_W'(20 + i);
            d0 = 32'hC000_0000 | 32'(i);
            d1 = 32'hC100_0000 | 32'(i);
            if (i != 0) @(negedge clk);
            drive(2'b11, a0, d0, a1, d1);
            #1;
            g_exp = (i % 2 == 0) ? 2'b01 : 2'b10;
            chk("cont_ready", 64'(req_ready), 64'(g_exp));
            exp_q.push_back((i % 2 == 0) ? {a0, d0} : {a1, d1});
            after_edge();
            chk("cont_wr_en", 64'(wr_en), 64'h1);
            got  = {wr_addr, wr_data};
            want = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            chk("cont_write", 64'(got), 64'(want));
        end
        chk("cont_q_empty", 64'(exp_q.size()), 64'h0);

        // vector table: rr_ptr is 0 here, drop_cnt is 0
        vecs[0]  = '{2'b01, 6'd5,  32'hA5A5_0001, 6'd0,  32'h0,        2'b01, 1'b1, 6'd5,  32'hA5A5_0001, 16'd0};
        vecs[1]  = '{2'b00, 6'd0,  32'h0,         6'd0,  32'h0,        2'b00, 1'b0, 6'd5,  32'hA5A5_0001, 16'd0};
        vecs[2]  = '{2'b11, 6'd3,  32'h11,        6'd7,  32'h22,       2'b10, 1'b1, 6'd7,  32'h22,        16'd0};
        vecs[3]  = '{2'b11, 6'd3,  32'h11,        6'd7,  32'h22,       2'b01, 1'b1, 6'd3,  32'h11,        16'd0};
        vecs[4]  = '{2'b01, 6'd4,  32'h44,        6'd0,  32'h0,        2'b01, 1'b1, 6'd4,  32'h44,        16'd0};
        vecs[5]  = '{2'b10, 6'd0,  32'h0,         6'd9,  32'h99,       2'b10, 1'b1, 6'd9,  32'h99,        16'd0};
        vecs[6]  = '{2'b01, 6'd0,  32'hDEAD,      6'd0,  32'h0,        2'b01, 1'b0, 6'd9,  32'h99,        16'd1};
        vecs[7]  = '{2'b10, 6'd0,  32'h0,         6'd40, 32'hBEEF,     2'b10, 1'b0, 6'd9,  32'h99,        16'd2};
        vecs[8]  = '{2'b10, 6'd0,  32'h0,         6'd31, 32'h31,       2'b10, 1'b1, 6'd31, 32'h31,        16'd2};
        vecs[9]  = '{2'b10, 6'd0,  32'h0,         6'd32, 32'h32,       2'b10, 1'b0, 6'd31, 32'h31,        16'd3};
        vecs[10] = '{2'b01, 6'd63, 32'h63,        6'd0,  32'h0,        2'b01, 1'b0, 6'd31, 32'h31,        16'd4};
        vecs[11] = '{2'b11, 6'd1,  32'h1,         6'd2,  32'h2,        2'b10, 1'b1, 6'd2,  32'h2,         16'd4};
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(vecs[i].valid, vecs[i].a0, vecs[i].d0, vecs[i].a1, vecs[i].d1);
            #1;
            chk("vec_ready", 64'(req_ready), 64'(vecs[i].exp_ready));
            after_edge();
            chk("vec_wr_en", 64'(wr_en), 64'(vecs[i].exp_wr_en));
            chk("vec_wr_addr", 64'(wr_addr), 64'(vecs[i].exp_addr));
            chk("vec_wr_data", 64'(wr_data), 64'(vecs[i].exp_data));
            chk("vec_drop", 64'(drop_cnt), 64'(vecs[i].exp_drop));
        end

        // drop counter saturation
        @(negedge clk);
        drive(2'b00, 6'd0, 32'h0, 6'd0, 32'h0);
        force dut.drop_cnt = 16'hFFFF;
        #1;
        release dut.drop_cnt;
        #1;
        drive(2'b01, 6'd0, 32'h5A, 6'd0, 32'h0);
        #1;
        chk("sat_ready", 64'(req_ready), 64'h1);
        after_edge();
        chk("sat_wr_en", 64'(wr_en), 64'h0);
        chk("sat_drop", 64'(drop_cnt), 64'hFFFF);

        // clear sweep with req0 pending; init_req wins
        @(negedge clk);
        drive(2'b01, 6'd12, 32'h1234, 6'd0, 32'h0);
        init_req = 1'b1;
        #1;
        chk("sw_start_ready", 64'(req_ready), 64'h0);
        for (int k = 0; k < DEPTH; k++) begin
            after_edge();
            init_req = (k >= 5 && k < 8);
            #1;
            chk("sw_ready", 64'(req_ready), 64'h0);
            chk("sw_wr_en", 64'(wr_en), 64'h1);
            chk("sw_wr_addr", 64'(wr_addr), 64'(k));
            chk("sw_wr_data", 64'(wr_data), 64'(INIT_VAL));
            chk("sw_busy", 64'(init_busy), 64'h1);
            chk("sw_state", 64'(dbg_state), 64'h1);
            chk("sw_done_low", 64'(init_done), 64'h0);
        end
        after_edge();
        chk("sw_done", 64'(init_done), 64'h1);
        chk("sw_end_wr_en", 64'(wr_en), 64'h0);
        chk("sw_end_busy", 64'(init_busy), 64'h0);
        chk("sw_end_ready", 64'(req_ready), 64'h1);
        after_edge();
        chk("sw_post_wr_en", 64'(wr_en), 64'h1);
        chk("sw_post_addr", 64'(wr_addr), 64'd12);
        chk("sw_post_data", 64'(wr_data), 64'h1234);
        chk("sw_post_done", 64'(init_done), 64'h0);
        chk("sw_post_drop", 64'(drop_cnt), 64'hFFFF);

        // async reset in the middle of a sweep
        @(negedge clk);
        drive(2'b00, 6'd0, 32'h0, 6'd0, 32'h0);
        init_req = 1'b1;
        after_edge();
        init_req = 1'b0;
        repeat (10) after_edge();
        chk("mid_addr", 64'(wr_addr), 64'd10);
        drive(2'b11, 6'd7, 32'h70, 6'd8, 32'h80);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_wr_en", 64'(wr_en), 64'h0);
        chk("mid_rst_busy", 64'(init_busy), 64'h0);
        chk("mid_rst_drop", 64'(drop_cnt), 64'h0);
        chk("mid_rst_addr", 64'(wr_addr), 64'h0);
        chk("mid_rst_state", 64'(dbg_state), 64'h0);
        chk("mid_rst_ready", 64'(req_ready), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_ready0", 64'(req_ready), 64'h1);
        after_edge();
        chk("post_rst_wr_en", 64'(wr_en), 64'h1);
        chk("post_rst_addr0", 64'(wr_addr), 64'd7);
        chk("post_rst_data0", 64'(wr_data), 64'h70);
        @(negedge clk);
        #1;
        chk("post_rst_ready1", 64'(req_ready), 64'h2);
        after_edge();
        chk("post_rst_addr1", 64'(wr_addr), 64'd8);
        chk("post_rst_data1", 64'(wr_data), 64'h80);
        chk("post_rst_busy", 64'(init_busy), 64'h0);

        @(negedge clk);
        drive(2'b00, 6'd0, 32'h0, 6'd0, 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
